// File: rtl/pcm_envelope.sv
// Envelope detector: rectify PCM, one-pole IIR smoothing, per-window envelope and peak.
// Optional build macro PCM_ENV_LOG_EN: env_out in {exp,mant} log format with one extra stage.
module pcm_envelope #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic        pcm_clk,
  input  logic        rst,
  input  logic        pcm_in_valid,
  output logic        pcm_in_ready,
  input  logic [15:0] pcm_in,
  input  logic [7:0]  win_len,
  input  logic [3:0]  alpha_shift,
  output logic        env_out_valid,
  input  logic        env_out_ready,
  output logic [15:0] env_out,
  output logic [15:0] peak_out,
  output logic [7:0]  overflow_cnt
);

  localparam int unsigned SH = ACC_W - 16;

  logic                    r_s1_valid;
  logic [15:0]             r_s1_a;
  logic signed [ACC_W:0]   r_y;
  logic [15:0]             r_pk;
  logic [CNT_W-1:0]        r_wc;

  logic [15:0]             w_abs;
  logic signed [ACC_W:0]   w_target;
  logic signed [ACC_W:0]   w_diff;
  logic signed [ACC_W:0]   w_step;
  logic signed [ACC_W:0]   w_y_new;
  logic [15:0]             w_pk_new;
  logic [CNT_W-1:0]        w_n;
  logic                    w_first;
  logic                    w_end;
  logic                    w_res_load;
  logic [15:0]             w_res_env;
  logic [15:0]             w_res_peak;

  assign pcm_in_ready = 1'b1;

  // Magnitude with -32768 clamped to the 15-bit maximum
  always_comb begin
    w_abs = pcm_in;
    if (pcm_in == 16'h8000) begin
      w_abs = 16'h7FFF;
    end else if (pcm_in[15]) begin
      w_abs = ~pcm_in + 16'd1;
    end
  end

  always_ff @(posedge pcm_clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= 16'd0;
    end else begin
      r_s1_valid <= pcm_in_valid;
      if (pcm_in_valid) begin
        r_s1_a <= w_abs;
      end
    end
  end

  // IIR update; r_y carries a spare sign bit so the difference never wraps
  assign w_target = $signed({1'b0, r_s1_a, {SH{1'b0}}});
  assign w_diff   = w_target - r_y;
  assign w_step   = w_diff >>> alpha_shift;
  assign w_y_new  = r_y + w_step;

  assign w_n      = (win_len == 8'd0) ? CNT_W'(1) : CNT_W'(win_len);
  assign w_first  = (r_wc == CNT_W'(1));
  assign w_end    = r_s1_valid && (r_wc >= w_n);
  assign w_pk_new = (w_first || (r_s1_a > r_pk)) ? r_s1_a : r_pk;

  always_ff @(posedge pcm_clk) begin
    if (rst) begin
      r_y  <= '0;
      r_pk <= 16'd0;
      r_wc <= CNT_W'(1);
    end else if (r_s1_valid) begin
      r_y  <= w_y_new;
      r_pk <= w_pk_new;
      r_wc <= w_end ? CNT_W'(1) : r_wc + CNT_W'(1);
    end
  end

`ifdef PCM_ENV_LOG_EN
  logic        r_s3_load;
  logic [15:0] r_s3_env;
  logic [15:0] r_s3_peak;

  // MSB index as exponent, the 12 bits under the MSB as mantissa
  function automatic logic [15:0] lin2log(input logic [15:0] v);
    logic [3:0] e;
    e = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) e = 4'(i);
    end
    if (v == 16'd0) return 16'd0;
    return {e, 12'((v << (4'd15 - e)) >> 3)};
  endfunction

  always_ff @(posedge pcm_clk) begin
    if (rst) begin
      r_s3_load <= 1'b0;
      r_s3_env  <= 16'd0;
      r_s3_peak <= 16'd0;
    end else begin
      r_s3_load <= w_end;
      if (w_end) begin
        r_s3_env  <= w_y_new[ACC_W-1 -: 16];
        r_s3_peak <= w_pk_new;
      end
    end
  end

  assign w_res_load = r_s3_load;
  assign w_res_env  = lin2log(r_s3_env);
  assign w_res_peak = r_s3_peak;
`else
  assign w_res_load = w_end;
  assign w_res_env  = w_y_new[ACC_W-1 -: 16];
  assign w_res_peak = w_pk_new;
`endif

  // Result holding register; unread results are overwritten and counted
  always_ff @(posedge pcm_clk) begin
    if (rst) begin
      env_out_valid <= 1'b0;
      env_out       <= 16'd0;
      peak_out      <= 16'd0;
      overflow_cnt  <= 8'd0;
    end else if (w_res_load) begin
      env_out       <= w_res_env;
      peak_out      <= w_res_peak;
      env_out_valid <= 1'b1;
      if (env_out_valid && !env_out_ready && (overflow_cnt != 8'hFF)) begin
        overflow_cnt <= overflow_cnt + 8'd1;
      end
    end else if (env_out_ready) begin
      env_out_valid <= 1'b0;
    end
  end

endmodule
